// File: rtl/memory_arbiter.sv
// memory_arbiter: single-port RAM arbiter between instruction fetch and data access.
// Optional starvation guard for fetches: define MEMARB_STARVE_GUARD_EN.
module memory_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_t r_state;

    logic w_dreq;
    logic w_access;
    logic w_error;
    logic w_force_i;
    logic w_grant_d;

    assign w_dreq   = dREN | dWEN;
    assign w_access = (ramstate == RAM_ACCESS);
    assign w_error  = (ramstate == RAM_ERROR);

`ifdef MEMARB_STARVE_GUARD_EN
    logic [1:0] r_starve;

    // A fetch passed over three data grants in a row wins the next tie.
    assign w_force_i = (r_starve == 2'd3) & iREN;
`else
    assign w_force_i = 1'b0;
`endif

    assign w_grant_d = w_dreq & ~w_force_i;

    // Grant state: arbitrate in IDLE, hold while RAM is FREE/BUSY.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant_d)
                        r_state <= DGNT;
                    else if (iREN)
                        r_state <= IGNT;
                end
                IGNT: begin
                    if (!iREN || w_access || w_error)
                        r_state <= IDLE;
                end
                DGNT: begin
                    if (!w_dreq || w_access || w_error)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MEMARB_STARVE_GUARD_EN
    // Count consecutive data grants taken while a fetch was waiting.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_starve <= 2'd0;
        end else if (r_state == IDLE) begin
            if (w_grant_d) begin
                if (!iREN)
                    r_starve <= 2'd0;
                else if (r_starve != 2'd3)
                    r_starve <= r_starve + 2'd1;
            end else if (iREN) begin
                r_starve <= 2'd0;
            end
        end
    end
`endif

    // RAM request and completion outputs follow the grant combinationally.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iload    = 32'd0;
        dload    = 32'd0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        memerr   = 1'b0;
        unique case (r_state)
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (iREN && w_access) begin
                    ihit  = 1'b1;
                    iload = ramload;
                end
                if (iREN && w_error)
                    memerr = 1'b1;
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (w_dreq && w_access) begin
                    dhit  = 1'b1;
                    dload = ramload;
                end
                if (w_dreq && w_error)
                    memerr = 1'b1;
            end
            default: ;
        endcase
        if (RST) begin
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = 32'd0;
            ramstore = 32'd0;
            iload    = 32'd0;
            dload    = 32'd0;
            ihit     = 1'b0;
            dhit     = 1'b0;
            memerr   = 1'b0;
        end
    end

endmodule
